// File: rtl/binclk_pkg.sv
// Shared types and constants for the binary clock time-setting logic.
package binclk_pkg;

    localparam int HOURS_W  = 5;
    localparam int MINSEC_W = 6;

    localparam logic [HOURS_W-1:0]  HOURS_MAX  = 5'd23;
    localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_COMMIT
    } state_t;

    // One step up or down with wrap-around; hours are passed zero-extended.
    function automatic logic [MINSEC_W-1:0] wrap_step(
        input logic [MINSEC_W-1:0] value,
        input logic [MINSEC_W-1:0] max_value,
        input logic                up
    );
        if (up)
            return (value >= max_value) ? '0 : value + 1'b1;
        else
            return (value == '0) ? max_value : value - 1'b1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_repeat.sv
// Button edge detect plus hold/auto-repeat step generator.
module btn_repeat #(
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_en,
    output logic o_press,
    output logic o_step
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

    logic              r_lvl;
    logic              r_prev;
    logic              r_repeating;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt;

    logic w_press;
    logic w_hold_step;
    logic w_rep_step;

    // A nonzero hold count means the hold was armed by a press while enabled.
    assign w_press     = r_lvl & ~r_prev;
    assign w_hold_step = i_en && r_lvl && !w_press && !r_repeating &&
                         (r_hold_cnt != '0) && (r_hold_cnt == HOLD_W'(HOLD_CYCLES));
    assign w_rep_step  = i_en && r_lvl && !w_press && r_repeating &&
                         (r_rep_cnt == REP_W'(REPEAT_CYCLES));

    assign o_press = w_press;
    assign o_step  = (i_en && w_press) || w_hold_step || w_rep_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl       <= 1'b1;
            r_prev      <= 1'b1;
            r_repeating <= 1'b0;
            r_hold_cnt  <= '0;
            r_rep_cnt   <= '0;
        end else begin
            r_lvl  <= i_btn;
            r_prev <= r_lvl;
            if (!i_en || !r_lvl) begin
                r_repeating <= 1'b0;
                r_hold_cnt  <= '0;
                r_rep_cnt   <= '0;
            end else if (w_press) begin
                r_repeating <= 1'b0;
                r_hold_cnt  <= HOLD_W'(1);
                r_rep_cnt   <= '0;
            end else if (r_hold_cnt != '0) begin
                if (!r_repeating) begin
                    if (w_hold_step) begin
                        r_repeating <= 1'b1;
                        r_rep_cnt   <= REP_W'(1);
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end else if (w_rep_step) begin
                    r_rep_cnt <= REP_W'(1);
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode button walks hours/minutes/seconds, inc/dec edit, commit loads the clock.
module time_set_ctrl
    import binclk_pkg::*;
#(
    parameter int HOLD_CYCLES    = 500,
    parameter int REPEAT_CYCLES  = 100,
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_btn_mode,
    input  logic                i_btn_inc,
    input  logic                i_btn_dec,
    input  logic [HOURS_W-1:0]  i_cur_hours,
    input  logic [MINSEC_W-1:0] i_cur_minutes,
    input  logic [MINSEC_W-1:0] i_cur_seconds,
    output logic [HOURS_W-1:0]  o_set_hours,
    output logic [MINSEC_W-1:0] o_set_minutes,
    output logic [MINSEC_W-1:0] o_set_seconds,
    output logic                o_load,
    output logic                o_run_en,
    output logic [1:0]          o_sel
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t              r_state;
    state_t              w_next;
    logic                r_mode_lvl;
    logic                r_mode_prev;
    logic [TO_W-1:0]     r_to_cnt;
    logic [HOURS_W-1:0]  r_set_hours;
    logic [MINSEC_W-1:0] r_set_minutes;
    logic [MINSEC_W-1:0] r_set_seconds;
    logic                r_load;
    logic                r_run_en;
    logic [1:0]          r_sel;

    logic                w_in_set;
    logic                w_mode_press;
    logic                w_inc_press;
    logic                w_dec_press;
    logic                w_inc_step;
    logic                w_dec_step;
    logic                w_adjust;
    logic                w_activity;
    logic                w_timeout;
    logic                w_load;
    logic                w_run_en;
    logic [1:0]          w_sel;
    logic [MINSEC_W-1:0] w_hours_wide;
    logic [MINSEC_W-1:0] w_minutes_next;
    logic [MINSEC_W-1:0] w_seconds_next;

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_inc (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (i_btn_inc),
        .i_en   (w_in_set),
        .o_press(w_inc_press),
        .o_step (w_inc_step)
    );

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_dec (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (i_btn_dec),
        .i_en   (w_in_set),
        .o_press(w_dec_press),
        .o_step (w_dec_step)
    );

    assign w_in_set     = (r_state == ST_SET_H) || (r_state == ST_SET_M) || (r_state == ST_SET_S);
    assign w_mode_press = r_mode_lvl & ~r_mode_prev;
    // Mode wins over inc/dec; simultaneous inc and dec cancel out.
    assign w_adjust     = w_in_set && !w_mode_press && (w_inc_step ^ w_dec_step);
    assign w_activity   = w_mode_press || w_inc_press || w_dec_press || w_inc_step || w_dec_step;
    assign w_timeout    = w_in_set && !w_activity && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign w_hours_wide   = wrap_step({1'b0, r_set_hours}, {1'b0, HOURS_MAX}, w_inc_step);
    assign w_minutes_next = wrap_step(r_set_minutes, MINSEC_MAX, w_inc_step);
    assign w_seconds_next = wrap_step(r_set_seconds, MINSEC_MAX, w_inc_step);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:    if (w_mode_press) w_next = ST_SET_H;
            ST_SET_H:  if (w_mode_press) w_next = ST_SET_M; else if (w_timeout) w_next = ST_RUN;
            ST_SET_M:  if (w_mode_press) w_next = ST_SET_S; else if (w_timeout) w_next = ST_RUN;
            ST_SET_S:  if (w_mode_press) w_next = ST_COMMIT; else if (w_timeout) w_next = ST_RUN;
            ST_COMMIT: w_next = ST_RUN;
            default:   w_next = ST_RUN;
        endcase

        w_load   = (w_next == ST_COMMIT);
        w_run_en = (w_next == ST_RUN);
        case (w_next)
            ST_SET_H: w_sel = 2'd1;
            ST_SET_M: w_sel = 2'd2;
            ST_SET_S: w_sel = 2'd3;
            default:  w_sel = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_mode_lvl    <= 1'b1;
            r_mode_prev   <= 1'b1;
            r_to_cnt      <= '0;
            r_set_hours   <= '0;
            r_set_minutes <= '0;
            r_set_seconds <= '0;
            r_load        <= 1'b0;
            r_run_en      <= 1'b1;
            r_sel         <= 2'd0;
        end else begin
            r_state     <= w_next;
            r_mode_lvl  <= i_btn_mode;
            r_mode_prev <= r_mode_lvl;
            r_load      <= w_load;
            r_run_en    <= w_run_en;
            r_sel       <= w_sel;

            if (!w_in_set || w_activity)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            // Capture the live time on entry so editing starts from the current reading.
            if (r_state == ST_RUN && w_mode_press) begin
                r_set_hours   <= i_cur_hours;
                r_set_minutes <= i_cur_minutes;
                r_set_seconds <= i_cur_seconds;
            end else if (w_adjust) begin
                case (r_state)
                    ST_SET_H: r_set_hours   <= w_hours_wide[HOURS_W-1:0];
                    ST_SET_M: r_set_minutes <= w_minutes_next;
                    ST_SET_S: r_set_seconds <= w_seconds_next;
                    default:  ;
                endcase
            end
        end
    end

    assign o_set_hours   = r_set_hours;
    assign o_set_minutes = r_set_minutes;
    assign o_set_seconds = r_set_seconds;
    assign o_load        = r_load;
    assign o_run_en      = r_run_en;
    assign o_sel         = r_sel;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed scoreboard bench for time_set_ctrl with short hold/repeat/timeout parameters.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btnMode, btnInc, btnDec;
    logic [4:0] curHours;
    logic [5:0] curMinutes, curSeconds;
    logic [4:0] setHours;
    logic [5:0] setMinutes, setSeconds;
    logic       load, runEn;
    logic [1:0] sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       runEn;
        logic       load;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } exp_t;

    exp_t expQ[$];

    time_set_ctrl #(
        .HOLD_CYCLES   (4),
        .REPEAT_CYCLES (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_mode   (btnMode),
        .i_btn_inc    (btnInc),
        .i_btn_dec    (btnDec),
        .i_cur_hours  (curHours),
        .i_cur_minutes(curMinutes),
        .i_cur_seconds(curSeconds),
        .o_set_hours  (setHours),
        .o_set_minutes(setMinutes),
        .o_set_seconds(setSeconds),
        .o_load       (load),
        .o_run_en     (runEn),
        .o_sel        (sel)
    );

    always #5 clk = ~clk;

    task automatic cmpField(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [1:0] s, input logic r, input logic l,
                           input logic [4:0] h, input logic [5:0] m, input logic [5:0] sec);
        exp_t e;
        e.tag = tag; e.sel = s; e.runEn = r; e.load = l; e.h = h; e.m = m; e.s = sec;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = expQ.pop_front();
            cmpField(e.tag, "sel",    8'(sel),        8'(e.sel));
            cmpField(e.tag, "run_en", 8'(runEn),      8'(e.runEn));
            cmpField(e.tag, "load",   8'(load),       8'(e.load));
            cmpField(e.tag, "hours",  8'(setHours),   8'(e.h));
            cmpField(e.tag, "mins",   8'(setMinutes), 8'(e.m));
            cmpField(e.tag, "secs",   8'(setSeconds), 8'(e.s));
        end
    endtask

    // Drive levels at a falling edge; they are sampled by the next rising edge.
    task automatic applyStimulus(input logic m, input logic i, input logic d);
        btnMode = m;
        btnInc  = i;
        btnDec  = d;
        @(negedge clk);
    endtask

    task automatic stepExp(input logic m, input logic i, input logic d, input string tag,
                           input logic [1:0] s, input logic r, input logic l,
                           input logic [4:0] h, input logic [5:0] mi, input logic [5:0] sec);
        pushExp(tag, s, r, l, h, mi, sec);
        applyStimulus(m, i, d);
        checkOutput();
    endtask

    initial begin
        int holdExp[1:9];
        holdExp = '{10, 11, 11, 11, 11, 12, 12, 13, 13};

        rst = 1'b1; btnMode = 1'b0; btnInc = 1'b0; btnDec = 1'b0;
        curHours = 5'd12; curMinutes = 6'd34; curSeconds = 6'd56;
        @(negedge clk);
        @(negedge clk);
        stepExp(0, 0, 0, "reset", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        stepExp(0, 0, 0, "idle_run_a", 0, 1, 0, 0, 0, 0);
        stepExp(0, 0, 0, "idle_run_b", 0, 1, 0, 0, 0, 0);

        // Walk through all fields and commit the captured time.
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "enter_set_h", 1, 0, 0, 12, 34, 56);
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "to_set_m",    2, 0, 0, 12, 34, 56);
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "to_set_s",    3, 0, 0, 12, 34, 56);
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "commit",      0, 0, 1, 12, 34, 56);
        stepExp(0, 0, 0, "after_commit", 0, 1, 0, 12, 34, 56);

        // Wrap boundaries, cancellation and mode priority.
        curHours = 5'd23; curMinutes = 6'd0; curSeconds = 6'd10;
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "s2_set_h",       1, 0, 0, 23, 0, 10);
        applyStimulus(0, 1, 0); stepExp(0, 0, 0, "hour_inc_wrap",  1, 0, 0, 0, 0, 10);
        applyStimulus(0, 0, 1); stepExp(0, 0, 0, "hour_dec_wrap",  1, 0, 0, 23, 0, 10);
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "s2_set_m",       2, 0, 0, 23, 0, 10);
        applyStimulus(0, 0, 1); stepExp(0, 0, 0, "min_dec_wrap",   2, 0, 0, 23, 59, 10);
        applyStimulus(0, 1, 1); stepExp(0, 0, 0, "inc_dec_cancel", 2, 0, 0, 23, 59, 10);
        applyStimulus(1, 1, 0); stepExp(0, 0, 0, "mode_beats_inc", 3, 0, 0, 23, 59, 10);

        // Held inc: step at press, then after 4 cycles, then every 2.
        for (int k = 1; k <= 9; k++)
            stepExp(0, 1, 0, $sformatf("hold_%0d", k), 3, 0, 0, 23, 59, 6'(holdExp[k]));
        stepExp(0, 0, 0, "hold_release", 3, 0, 0, 23, 59, 14);
        stepExp(0, 0, 0, "hold_settled", 3, 0, 0, 23, 59, 14);

        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "s3_commit", 0, 0, 1, 23, 59, 14);
        stepExp(0, 0, 0, "s3_run", 0, 1, 0, 23, 59, 14);

        // Idle timeout aborts the edit without a load.
        curHours = 5'd5; curMinutes = 6'd6; curSeconds = 6'd7;
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "s3_set_h", 1, 0, 0, 5, 6, 7);
        for (int k = 1; k <= 19; k++)
            stepExp(0, 0, 0, $sformatf("idle_%0d", k), 1, 0, 0, 5, 6, 7);
        stepExp(0, 0, 0, "timeout", 0, 1, 0, 5, 6, 7);

        // Inc held in RUN and carried into SET_H must not repeat.
        for (int k = 1; k <= 6; k++)
            stepExp(0, 1, 0, $sformatf("run_inc_%0d", k), 0, 1, 0, 5, 6, 7);
        applyStimulus(1, 1, 0); stepExp(0, 1, 0, "set_h_inc_held", 1, 0, 0, 5, 6, 7);
        for (int k = 1; k <= 6; k++)
            stepExp(0, 1, 0, $sformatf("no_repeat_%0d", k), 1, 0, 0, 5, 6, 7);
        stepExp(0, 0, 0, "inc_released", 1, 0, 0, 5, 6, 7);

        // Reset mid-edit with the mode button held through it.
        applyStimulus(0, 1, 0); stepExp(0, 0, 0, "s4_hour_inc", 1, 0, 0, 6, 6, 7);
        applyStimulus(1, 0, 0); stepExp(0, 0, 0, "s4_set_m",    2, 0, 0, 6, 6, 7);
        rst = 1'b1;
        stepExp(1, 0, 0, "reset_mid_edit", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++)
            stepExp(1, 0, 0, $sformatf("held_thru_reset_%0d", k), 0, 1, 0, 0, 0, 0);
        stepExp(0, 0, 0, "mode_released_a", 0, 1, 0, 0, 0, 0);
        stepExp(0, 0, 0, "mode_released_b", 0, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 500: cycles an inc/dec button is held before auto-repeat starts.
REQ-002 Parameter REPEAT_CYCLES, default 100: cycles between auto-repeat steps.
REQ-003 Parameter TIMEOUT_CYCLES, default 6000: idle cycles in any SET state before the edit is aborted.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 btn_mode, btn_inc, btn_dec  in  1 each  already synchronized and debounced button levels, active-high.
REQ-007 cur_hours  in  5; cur_minutes  in  6; cur_seconds  in  6: live time from the clock counters.
REQ-008 set_hours  out  5; set_minutes  out  6; set_seconds  out  6: edit values, valid when load=1.
REQ-009 load  out  1  one-cycle pulse; the clock counters take set_* on this cycle.
REQ-010 run_en  out  1  clock counter enable; 0 while editing.
REQ-011 sel  out  2  field under edit: 0 none, 1 hours, 2 minutes, 3 seconds (display blink select).

Function
REQ-012 All outputs are registered; a press whose rising edge is first sampled at edge N changes outputs at edge N+1.
REQ-013 A press is btn=1 with the registered previous level=0; a level held continuously produces only one press.
REQ-014 States: RUN, SET_H, SET_M, SET_S, COMMIT; sel=0 in RUN/COMMIT, 1/2/3 in SET_H/SET_M/SET_S.
REQ-015 RUN + mode press -> SET_H; cur_* captured into the edit registers in the same cycle; run_en=0.
REQ-016 SET_H -> SET_M -> SET_S on successive mode presses; SET_S + mode press -> COMMIT.
REQ-017 COMMIT lasts exactly one cycle with load=1, run_en=0; then RUN with run_en=1, load=0.
REQ-018 Inc step in a SET state: field+1, hours wrap 23->0, minutes/seconds wrap 59->0.
REQ-019 Dec step: field-1, hours 0->23, minutes/seconds 0->59; the other two fields are unchanged.
REQ-020 A step is generated by an inc/dec press, then after HOLD_CYCLES of continuous hold, then every REPEAT_CYCLES while still held.
REQ-021 Releasing the button clears its hold/repeat counter; counting restarts at the next press.
REQ-022 Simultaneous events: a mode press wins and inc/dec in that cycle is ignored; inc and dec steps in the same cycle cancel (no change).
REQ-023 Inc/dec presses and holds in RUN or COMMIT are ignored and do not start auto-repeat steps.
REQ-024 The timeout counter clears on entry to SET_H and on any press or step; reaching TIMEOUT_CYCLES in a SET state -> RUN, no load, run_en=1.
REQ-025 Edit registers hold their value outside SET states; set_* always drive the edit registers.

Reset
REQ-026 rst at any time, including mid-edit or in COMMIT: state=RUN, run_en=1, load=0, sel=0, set_*=0, all counters=0.
REQ-027 Previous-level registers reset to 1, so a button held through reset does not register a press.

Structure
REQ-028 The shared package binclk_pkg holds the state enum, HOURS_MAX=23, MINSEC_MAX=59, and the field widths 5/6/6.
REQ-029 One sub-module, btn_repeat (edge detect + hold/repeat counter, output one-cycle step), instantiated for inc and dec; the mode button uses edge detect only.
REQ-030 Counter widths are $clog2 of the respective parameter plus 1.

Verification (bench parameters HOLD=4, REPEAT=2, TIMEOUT=20)
REQ-031 Scenario: cur=12:34:56, mode press -> next cycle sel=1, run_en=0; mode x3 -> one cycle load=1 with set=12:34:56, then run_en=1, sel=0.
REQ-032 Scenario: in SET_H at hours=23, inc press -> 0; dec press -> 23. In SET_M at 0, dec press -> 59.
REQ-033 Scenario: in SET_S at 10, inc held 9 cycles -> steps at the press cycle, +4, +6, +8 -> 14.
REQ-034 Scenario: in SET_M, mode and inc rise in the same cycle -> SET_S with minutes unchanged; inc+dec same cycle -> no change.
REQ-035 Scenario: in SET_H, 20 idle cycles -> RUN, load never asserted, run_en=1.
REQ-036 Scenario: rst in SET_M with hours edited -> next cycle RUN, set_*=0, load=0; a button held through reset gives no press.
